// File: rtl/dcmi_tx_arbiter_pkg.sv
// Shared definitions for the DCMI transmit arbiter.
//   arb_state_e : arbiter FSM state encoding (idle, wait-for-start, frame, inter-frame gap)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, for counter/index widths
package dcmi_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StFrame = 2'd2,
    StGap   = 2'd3
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcmi_tx_arbiter_if.sv
// Bus bundle between the DCMI sources and the arbiter.
//   req      : per-channel frame request (level)
//   gnt      : one-hot grant, all-zero when idle
//   ch_data  : channel data, channel k at [k*DW +: DW]
//   ch_dsync : per-channel frame-valid
//   data     : muxed registered DCMI data
//   dsync    : muxed registered DCMI frame-valid
//   busy     : arbiter not idle
//   err      : sticky start-timeout flag
//   err_ch   : channel of the last start timeout
// Modports: master = sources side, slave = arbiter side.
interface dcmi_tx_arbiter_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8
);
  import dcmi_tx_arbiter_pkg::*;

  localparam int unsigned IW = clog2_min1(N_CH);

  logic [N_CH-1:0]    req;
  logic [N_CH-1:0]    gnt;
  logic [N_CH*DW-1:0] ch_data;
  logic [N_CH-1:0]    ch_dsync;
  logic [DW-1:0]      data;
  logic               dsync;
  logic               busy;
  logic               err;
  logic [IW-1:0]      err_ch;

  modport master (
    output req, ch_data, ch_dsync,
    input  gnt, data, dsync, busy, err, err_ch
  );

  modport slave (
    input  req, ch_data, ch_dsync,
    output gnt, data, dsync, busy, err, err_ch
  );

endinterface

// File: rtl/dcmi_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
//   i_req    : request vector
//   i_ptr    : search start position (0..N-1)
//   o_onehot : one-hot of the first requester at or after i_ptr, wrapping
//   o_idx    : index of that requester
//   o_valid  : any request present
module dcmi_tx_arbiter_rr_pick
  import dcmi_tx_arbiter_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int unsigned w_c;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_c      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_c = 32'(i_ptr) + i;
      if (w_c >= N) w_c = w_c - N;
      if (!o_valid && i_req[w_c[IW-1:0]]) begin
        o_valid               = 1'b1;
        o_idx                 = w_c[IW-1:0];
        o_onehot[w_c[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcmi_tx_arbiter.sv
// N-channel request/grant arbiter for the shared DCMI master bus.
// Round-robin selection, one source per frame, forced DSYNC-low gap between frames,
// start timeout revokes a grant whose channel never raises DSYNC.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_clken : DCMI clock enable; all state advances only when high
//   io_bus  : slave side of dcmi_tx_arbiter_if (req/gnt, channel inputs, muxed outputs,
//             busy, err, err_ch)
module dcmi_tx_arbiter
  import dcmi_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DW            = 8,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic             i_clken,
  dcmi_tx_arbiter_if.slave io_bus
);

  localparam int unsigned IW = clog2_min1(N_CH);
  localparam int unsigned TW = clog2_min1(START_TIMEOUT);
  localparam int unsigned GW = clog2_min1(GAP_TICKS);

  localparam logic [TW-1:0] TmoLast = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] GapLast = GW'(GAP_TICKS - 1);
  localparam logic [IW-1:0] IdxLast = IW'(N_CH - 1);

  arb_state_e    r_state;
  logic [N_CH-1:0] r_gnt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_ptr;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;
  logic [DW-1:0] r_data;
  logic          r_dsync;
  logic          r_err;
  logic [IW-1:0] r_err_ch;

  logic [N_CH-1:0] w_pick_onehot;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic [DW-1:0]   w_ch_data;
  logic            w_ch_dsync;
  logic            w_ch_req;

  dcmi_tx_arbiter_rr_pick #(
    .N (N_CH)
  ) u_rr_pick (
    .i_req    (io_bus.req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Only the granted channel's signals are ever selected; others cannot leak out.
  always_comb begin
    w_ch_data  = '0;
    w_ch_dsync = 1'b0;
    w_ch_req   = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (r_idx == IW'(k)) begin
        w_ch_data  = io_bus.ch_data[k*DW +: DW];
        w_ch_dsync = io_bus.ch_dsync[k];
        w_ch_req   = io_bus.req[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_gnt    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_tmo    <= '0;
      r_gap    <= '0;
      r_data   <= '0;
      r_dsync  <= 1'b0;
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end else if (i_clken) begin
      // Bus outputs default to zero; WAIT/FRAME override with the granted channel.
      r_data  <= '0;
      r_dsync <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pick_valid) begin
            r_gnt   <= w_pick_onehot;
            r_idx   <= w_pick_idx;
            r_ptr   <= (w_pick_idx == IdxLast) ? '0 : w_pick_idx + 1'b1;
            r_tmo   <= '0;
            r_state <= StWait;
          end
        end
        StWait: begin
          r_data  <= w_ch_data;
          r_dsync <= w_ch_dsync;
          if (w_ch_dsync) begin
            r_state <= StFrame;
          end else if (!w_ch_req) begin
            r_gnt   <= '0;
            r_gap   <= '0;
            r_state <= StGap;
          end else if (r_tmo == TmoLast) begin
            r_gnt    <= '0;
            r_err    <= 1'b1;
            r_err_ch <= r_idx;
            r_gap    <= '0;
            r_state  <= StGap;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        StFrame: begin
          if (w_ch_dsync) begin
            r_data  <= w_ch_data;
            r_dsync <= 1'b1;
          end else begin
            // Frame end registers DSYNC=0 and DATA=0 via the defaults above.
            r_gnt   <= '0;
            r_gap   <= '0;
            r_state <= StGap;
          end
        end
        StGap: begin
          if (r_gap == GapLast) r_state <= StIdle;
          else                  r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.gnt    = r_gnt;
  assign io_bus.data   = r_data;
  assign io_bus.dsync  = r_dsync;
  assign io_bus.busy   = (r_state != StIdle);
  assign io_bus.err    = r_err;
  assign io_bus.err_ch = r_err_ch;

endmodule

// File: tb/tb_dcmi_tx_arbiter.sv
// Self-checking bench for dcmi_tx_arbiter: scoreboard queues for expected frame data and
// grant order, filled as stimulus is driven and drained by a negedge monitor, plus direct
// checks of grant timing, gap length, timeout, isolation, async reset and clock enable.
module tb_dcmi_tx_arbiter;
  import dcmi_tx_arbiter_pkg::*;

  localparam int unsigned N_CH          = 4;
  localparam int unsigned DW            = 8;
  localparam int unsigned GAP_TICKS     = 2;
  localparam int unsigned START_TIMEOUT = 16;

  logic clk;
  logic rst_n;
  logic clken;

  dcmi_tx_arbiter_if #(.N_CH(N_CH), .DW(DW)) bus ();

  dcmi_tx_arbiter #(
    .N_CH          (N_CH),
    .DW            (DW),
    .GAP_TICKS     (GAP_TICKS),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clken (clken),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0]   q_data[$];
  logic [N_CH-1:0] q_gnt[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: only evaluates after CLK edges that were real ticks.
  logic            tick_q = 1'b0;
  logic [N_CH-1:0] prev_gnt = '0;

  always @(posedge clk) tick_q <= clken & rst_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt <= '0;
    end else if (tick_q) begin
      if (bus.dsync) begin
        check_eq("data_pending", 32'(q_data.size() != 0), 32'd1);
        if (q_data.size() != 0) check_eq("data", 32'(bus.data), 32'(q_data.pop_front()));
      end
      if (prev_gnt == '0 && bus.gnt != '0) begin
        check_eq("gnt_pending", 32'(q_gnt.size() != 0), 32'd1);
        if (q_gnt.size() != 0) check_eq("gnt_order", 32'(bus.gnt), 32'(q_gnt.pop_front()));
      end
      prev_gnt <= bus.gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (bus.gnt == '0 && n < 200) begin
      tick();
      n++;
    end
    check_eq("gnt_wait", 32'(bus.gnt != '0), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    check_eq("idle_wait", 32'(bus.busy), 32'd0);
  endtask

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Drives len DSYNC-high ticks of base, base+1, ... on channel k, then drops DSYNC.
  task automatic drive_frame(input int k, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      bus.ch_dsync[k]           = 1'b1;
      bus.ch_data[k*DW +: DW]   = base + DW'(i);
      q_data.push_back(base + DW'(i));
      tick();
    end
    bus.ch_dsync[k]         = 1'b0;
    bus.ch_data[k*DW +: DW] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    q_data.delete();
    q_gnt.delete();
  endtask

  initial begin
    int n;
    int k;
    rst_n        = 1'b0;
    clken        = 1'b1;
    bus.req      = '0;
    bus.ch_data  = '0;
    bus.ch_dsync = '0;
    #2;
    check_eq("rst_gnt", 32'(bus.gnt), 32'd0);
    check_eq("rst_data", 32'(bus.data), 32'd0);
    check_eq("rst_dsync", 32'(bus.dsync), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_err_ch", 32'(bus.err_ch), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single frame on ch2
    bus.req = 4'b0100;
    q_gnt.push_back(4'b0100);
    tick();
    check_eq("t1_gnt", 32'(bus.gnt), 32'h4);
    check_eq("t1_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    drive_frame(2, 8, 8'd0);
    tick();
    check_eq("t1_gnt_drop", 32'(bus.gnt), 32'd0);
    check_eq("t1_dsync_drop", 32'(bus.dsync), 32'd0);
    check_eq("t1_data_drop", 32'(bus.data), 32'd0);
    check_eq("t1_busy_gap0", 32'(bus.busy), 32'd1);
    tick();
    check_eq("t1_busy_gap1", 32'(bus.busy), 32'd1);
    tick();
    check_eq("t1_busy_end", 32'(bus.busy), 32'd0);

    // 2: all requesting, round-robin order 0,1,2,3,0 with fixed gap
    do_reset();
    tick();
    q_gnt.push_back(4'b0001);
    q_gnt.push_back(4'b0010);
    q_gnt.push_back(4'b0100);
    q_gnt.push_back(4'b1000);
    q_gnt.push_back(4'b0001);
    bus.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(n);
      if (f > 0) check_eq("t2_gap", 32'(n), 32'(GAP_TICKS + 1));
      k = onehot_idx(bus.gnt);
      if (f == 4) bus.req = '0;
      drive_frame(k, 3, DW'(8'h10 * (f + 1)));
      tick();
      check_eq("t2_gnt_drop", 32'(bus.gnt), 32'd0);
    end
    wait_idle();

    // 3: ch1 granted but never starts -> timeout, then ch2
    bus.req = 4'b0110;
    q_gnt.push_back(4'b0010);
    wait_gnt(n);
    check_eq("t3_gnt1", 32'(bus.gnt), 32'h2);
    n = 0;
    while (bus.gnt != '0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("t3_tmo_ticks", 32'(n), 32'(START_TIMEOUT));
    check_eq("t3_err", 32'(bus.err), 32'd1);
    check_eq("t3_err_ch", 32'(bus.err_ch), 32'd1);
    q_gnt.push_back(4'b0100);
    wait_gnt(n);
    check_eq("t3_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();
    check_eq("t3_withdraw", 32'(bus.gnt), 32'd0);
    wait_idle();

    // 4: ch3 drives garbage during a ch0 frame
    bus.req = 4'b0001;
    q_gnt.push_back(4'b0001);
    wait_gnt(n);
    bus.req                  = '0;
    bus.ch_dsync[3]          = 1'b1;
    bus.ch_data[3*DW +: DW]  = 8'hFF;
    drive_frame(0, 4, 8'hA0);
    bus.ch_dsync[3]          = 1'b0;
    bus.ch_data[3*DW +: DW]  = '0;
    tick();
    check_eq("t4_err_sticky", 32'(bus.err), 32'd1);
    wait_idle();

    // 5: async reset mid-frame, then ch3 granted from pointer 0
    bus.req = 4'b1000;
    q_gnt.push_back(4'b1000);
    wait_gnt(n);
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      bus.ch_dsync[3]         = 1'b1;
      bus.ch_data[3*DW +: DW] = DW'(8'h50 + i);
      q_data.push_back(DW'(8'h50 + i));
      tick();
    end
    check_eq("t5_pre_dsync", 32'(bus.dsync), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_data", 32'(bus.data), 32'd0);
    check_eq("t5_dsync", 32'(bus.dsync), 32'd0);
    check_eq("t5_gnt", 32'(bus.gnt), 32'd0);
    check_eq("t5_busy", 32'(bus.busy), 32'd0);
    check_eq("t5_err", 32'(bus.err), 32'd0);
    q_data.delete();
    q_gnt.delete();
    bus.ch_dsync = '0;
    bus.ch_data  = '0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req = 4'b1000;
    q_gnt.push_back(4'b1000);
    tick();
    check_eq("t5_regrant", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    tick();
    wait_idle();

    // 6: clock enable held low freezes the arbiter
    clken   = 1'b0;
    bus.req = 4'b0001;
    repeat (10) tick();
    check_eq("t6_gnt_hold", 32'(bus.gnt), 32'd0);
    check_eq("t6_busy_hold", 32'(bus.busy), 32'd0);
    check_eq("t6_data_hold", 32'(bus.data), 32'd0);
    q_gnt.push_back(4'b0001);
    clken = 1'b1;
    tick();
    check_eq("t6_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    wait_idle();

    check_eq("q_data_empty", 32'(q_data.size()), 32'd0);
    check_eq("q_gnt_empty", 32'(q_gnt.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
